// File: rtl/tanimoto_pkg.sv
// Shared definitions for the tanimoto result-stream blocks: ID/pair widths,
// the ID-pair packer state encoding and the idle-counter width helper.
package tanimoto_pkg;

  localparam int unsigned VEC_ID_WIDTH   = 10;
  localparam int unsigned PAIR_WIDTH     = 2 * VEC_ID_WIDTH;
  localparam int unsigned PAIRS_PER_WORD = 512 / PAIR_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFullWait,
    StFlushWait
  } packer_state_e;

  // Bits needed to count from 0 up to timeout inclusive, never less than one.
  function automatic int unsigned idle_cnt_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/id_word_out_reg.sv
// Output register slice for a packed result word: loads a word plus its pair
// count and holds it on a valid/ready stream until the downstream accepts it.
module id_word_out_reg #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic [CNT_W-1:0] load_pairs,
  input  logic             ready,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] pairs,
  output logic             valid
);

  // Load a new word (caller guarantees the slot is free); drop valid on handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word  <= '0;
      pairs <= '0;
      valid <= 1'b0;
    end else if (load) begin
      word  <= load_word;
      pairs <= load_pairs;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/id_pair_packer.sv
// Drains ID pairs from tanimoto_top and packs them LSB-first into BUS_WIDTH-bit
// words, double-buffered behind id_word_out_reg. Partial words leave on i_Flush.
// Optional feature: define ID_PACKER_TIMEOUT_EN to add an idle-timeout flush.
module id_pair_packer #(
  parameter int unsigned BUS_WIDTH      = 512,
  parameter int unsigned VEC_ID_WIDTH   = tanimoto_pkg::VEC_ID_WIDTH,
  parameter int unsigned PAIRS_PER_WORD = BUS_WIDTH / (2 * VEC_ID_WIDTH),
  parameter int unsigned FLUSH_TIMEOUT  = 256
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  i_IDPair_Ready,
  input  logic [2*VEC_ID_WIDTH-1:0]             i_IDPair_In,
  output logic                                  o_IDPair_Read,
  input  logic                                  i_Flush,
  output logic [BUS_WIDTH-1:0]                  o_Word,
  output logic [$clog2(PAIRS_PER_WORD+1)-1:0]   o_WordPairs,
  output logic                                  o_Valid,
  input  logic                                  i_Ready,
  output logic [31:0]                           o_PairCount
);
  import tanimoto_pkg::*;

  localparam int unsigned PAIR_W = 2 * VEC_ID_WIDTH;
  localparam int unsigned ASM_W  = PAIRS_PER_WORD * PAIR_W;
  localparam int unsigned CNT_W  = $clog2(PAIRS_PER_WORD + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAIRS_PER_WORD);

  logic [ASM_W-1:0]     asm_q, asm_d, asm_merged;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_merged;
  packer_state_e        state_q, state_d;
  logic [31:0]          pair_count_q;
  logic                 out_busy, stall, accept, flush_req, timeout_flush, transfer;
  logic [BUS_WIDTH-1:0] xfer_word;
  logic [CNT_W-1:0]     xfer_pairs;

  assign out_busy = o_Valid & ~i_Ready;
  assign stall    = (cnt_q == CNT_FULL) & out_busy;
  // Read is forced low while reset is asserted so no pair is lost at reset.
  assign accept        = i_IDPair_Ready & ~stall & rstn;
  assign o_IDPair_Read = accept;
  // StFlushWait doubles as the pending-flush flag.
  assign flush_req = i_Flush | timeout_flush | (state_q == StFlushWait);

`ifdef ID_PACKER_TIMEOUT_EN
  localparam int unsigned IDLE_W = idle_cnt_width(FLUSH_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_TIMEOUT - 1);
  logic [IDLE_W-1:0] idle_q;

  assign timeout_flush = (cnt_q != '0) && (idle_q == IDLE_LAST);

  // Count idle cycles since the last accepted pair or word transfer; saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_q <= '0;
    end else if (accept || transfer) begin
      idle_q <= '0;
    end else if (idle_q != IDLE_LAST) begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end
`else
  assign timeout_flush = 1'b0;
`endif

  // Place the incoming pair in the next free slot of a not-yet-full word.
  always_comb begin
    asm_merged = asm_q;
    cnt_merged = cnt_q;
    if (accept && (cnt_q != CNT_FULL)) begin
      for (int unsigned i = 0; i < PAIRS_PER_WORD; i++) begin
        if (cnt_q == CNT_W'(i)) asm_merged[i*PAIR_W +: PAIR_W] = i_IDPair_In;
      end
      cnt_merged = cnt_q + CNT_W'(1);
    end
  end

  // Decide on a transfer to the output slice and compute next assembly/state.
  always_comb begin
    transfer   = 1'b0;
    xfer_word  = '0;
    xfer_pairs = '0;
    asm_d      = asm_merged;
    cnt_d      = cnt_merged;
    state_d    = state_q;
    if (cnt_q == CNT_FULL) begin
      // A pair accepted alongside a full word starts the next word.
      if (!out_busy) begin
        transfer   = 1'b1;
        xfer_word  = BUS_WIDTH'(asm_q);
        xfer_pairs = cnt_q;
        asm_d      = accept ? ASM_W'(i_IDPair_In) : '0;
        cnt_d      = CNT_W'(accept);
      end
    end else if (!out_busy &&
                 ((cnt_merged == CNT_FULL) || (flush_req && (cnt_merged != '0)))) begin
      transfer   = 1'b1;
      xfer_word  = BUS_WIDTH'(asm_merged);
      xfer_pairs = cnt_merged;
      asm_d      = '0;
      cnt_d      = '0;
    end
    if (cnt_d == '0) begin
      state_d = StIdle;
    end else if (!transfer && flush_req) begin
      state_d = StFlushWait;
    end else if (cnt_d == CNT_FULL) begin
      state_d = StFullWait;
    end else begin
      state_d = StFill;
    end
  end

  // Assembly register, fill count and FSM state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      asm_q   <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
    end else begin
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Running total of accepted pairs, wrapping at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pair_count_q <= '0;
    end else if (accept) begin
      pair_count_q <= pair_count_q + 32'd1;
    end
  end

  assign o_PairCount = pair_count_q;

  id_word_out_reg #(
    .WIDTH (BUS_WIDTH),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rstn       (rstn),
    .load       (transfer),
    .load_word  (xfer_word),
    .load_pairs (xfer_pairs),
    .ready      (i_Ready),
    .word       (o_Word),
    .pairs      (o_WordPairs),
    .valid      (o_Valid)
  );

endmodule
